// File: rtl/complete_cdb_buffer_pkg.sv
// Shared types and sizing constants for the FU-complete / CDB buffer slice.
// Optional build macro: CDB_BYPASS_EN (see complete_cdb_buffer.sv).
package complete_cdb_buffer_pkg;

    localparam int XLEN          = 32;
    localparam int PR_IDX_W      = 6;
    localparam int ROB_IDX_W     = 5;
    localparam int N_CDB_SRC     = 6;
    localparam int CDB_BUF_DEPTH = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PR_IDX_W-1:0]  pr_idx;
        logic [XLEN-1:0]      dest_value;
    } FU_COMPLETE_PACKET;

endpackage

// File: rtl/complete_cdb_buffer_if.sv
// FU-complete source lanes plus CDB/PRF broadcast bundle.
// slave = the buffer, master = the FU / ROB environment driving it.
interface complete_cdb_if
    import complete_cdb_buffer_pkg::*;
#(
    parameter int N_SRC = N_CDB_SRC,
    parameter int DEPTH = CDB_BUF_DEPTH
);
    logic [N_SRC-1:0]                    src_valid;
    FU_COMPLETE_PACKET [N_SRC-1:0]       src_packet;
    logic [N_SRC-1:0]                    src_ready;
    logic                                squash;
    logic                                cdb_ready;
    logic                                cdb_valid;
    FU_COMPLETE_PACKET                   cdb_packet;
    logic                                prf_wr_en;
    logic [PR_IDX_W-1:0]                 prf_wr_idx;
    logic [XLEN-1:0]                     prf_wr_value;
    logic [$clog2(DEPTH+1)-1:0]          occupancy;
    logic                                fu_stall;

    modport slave (
        input  src_valid, src_packet, squash, cdb_ready,
        output src_ready, cdb_valid, cdb_packet, prf_wr_en, prf_wr_idx,
               prf_wr_value, occupancy, fu_stall
    );

    modport master (
        output src_valid, src_packet, squash, cdb_ready,
        input  src_ready, cdb_valid, cdb_packet, prf_wr_en, prf_wr_idx,
               prf_wr_value, occupancy, fu_stall
    );

endinterface

// File: rtl/complete_cdb_buffer_rr_arb.sv
// Round-robin arbiter: first requesting lane at or after rr_ptr, wrapping.
module complete_rr_arb #(
    parameter int N_SRC = 6,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             enable,
    output logic [N_SRC-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int               j;
    logic [IDX_W-1:0] j_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        j_idx       = '0;
        for (int k = 0; k < N_SRC; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_SRC) j = j - N_SRC;
            j_idx = IDX_W'(j);
            if (enable && !grant_valid && req[j_idx]) begin
                grant_valid  = 1'b1;
                grant[j_idx] = 1'b1;
                grant_idx    = j_idx;
            end
        end
    end

endmodule

// File: rtl/complete_cdb_buffer.sv
// In-order FIFO between FU completion lanes and the CDB broadcast with PRF write.
// Define CDB_BUF_BYPASS-free default; define CDB_BYPASS_EN for same-cycle empty-FIFO bypass.
module complete_cdb_buffer
    import complete_cdb_buffer_pkg::*;
#(
    parameter int N_SRC = N_CDB_SRC,
    parameter int DEPTH = CDB_BUF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    complete_cdb_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(N_SRC);
    localparam int OCC_W = $clog2(DEPTH+1);

    FU_COMPLETE_PACKET mem [DEPTH];
    FU_COMPLETE_PACKET grant_pkt;
    FU_COMPLETE_PACKET cdb_pkt;

    logic [PTR_W-1:0] head, tail;
    logic [OCC_W-1:0] occ;
    logic [IDX_W-1:0] rr_ptr;
    logic [N_SRC-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             live, empty, full, arb_en, fifo_pop, push, bypass;

    // Squash and reset both silence the buffer for the current cycle.
    assign live  = reset && !bus.squash;
    assign empty = (occ == '0);
    assign full  = (occ == OCC_W'(DEPTH));

    // Full implies non-empty, so cdb_ready alone tells us a pop frees a slot.
    assign fifo_pop = live && !empty && bus.cdb_ready;
    assign arb_en   = live && (!full || bus.cdb_ready);

    complete_rr_arb #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_arb (
        .req         (bus.src_valid),
        .rr_ptr      (rr_ptr),
        .enable      (arb_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign grant_pkt = bus.src_packet[grant_idx];

`ifdef CDB_BYPASS_EN
    assign bypass = empty && grant_valid && bus.cdb_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = grant_valid && !bypass;

    always_comb begin
        cdb_pkt = '0;
        if (bypass)
            cdb_pkt = grant_pkt;
        else if (live && !empty)
            cdb_pkt = mem[head];
    end

    assign bus.src_ready    = grant;
    assign bus.cdb_valid    = bypass || (live && !empty);
    assign bus.cdb_packet   = cdb_pkt;
    assign bus.prf_wr_en    = bus.cdb_valid && bus.cdb_ready && cdb_pkt.valid;
    assign bus.prf_wr_idx   = cdb_pkt.pr_idx;
    assign bus.prf_wr_value = cdb_pkt.dest_value;
    assign bus.occupancy    = occ;
    assign bus.fu_stall     = full;

    // Control state: pointers, count and arbitration pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            rr_ptr <= '0;
        end else begin
            if (grant_valid)
                rr_ptr <= (grant_idx == IDX_W'(N_SRC-1)) ? '0 : grant_idx + 1'b1;
            if (bus.squash) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (push)     tail <= tail + 1'b1;
                if (fifo_pop) head <= head + 1'b1;
                occ <= occ + OCC_W'(push) - OCC_W'(fifo_pop);
            end
        end
    end

    // Storage holds data only; validity is tracked by occ.
    always_ff @(posedge clock) begin
        if (push)
            mem[tail] <= grant_pkt;
    end

endmodule

// File: tb/tb_complete_cdb_buffer.sv
// Directed self-checking bench for complete_cdb_buffer (default and CDB_BYPASS_EN builds).
module tb_complete_cdb_buffer;
    import complete_cdb_buffer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   pass_cnt = 0;
    int   total    = 0;

    always #5 clock = ~clock;

    complete_cdb_if #(.N_SRC(6), .DEPTH(4)) bus ();

    complete_cdb_buffer #(.N_SRC(6), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic FU_COMPLETE_PACKET mkpkt(input logic v, input int pr, input logic [31:0] val);
        FU_COMPLETE_PACKET p;
        p.valid      = v;
        p.rob_idx    = ROB_IDX_W'(pr);
        p.pr_idx     = PR_IDX_W'(pr);
        p.dest_value = val;
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [5:0] exp_rdy;

    initial begin
        bus.src_valid = '0;
        for (int i = 0; i < 6; i++) bus.src_packet[i] = '0;
        bus.squash    = 1'b0;
        bus.cdb_ready = 1'b0;

        // 1. reset, idle lanes
        step();
        step();
        #1;
        check("rst_cdb_valid", bus.cdb_valid, 0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_src_ready", bus.src_ready, 0);
        check("rst_fu_stall", bus.fu_stall, 0);
        reset = 1'b1;
        step();

        // 2. single packet on lane 2
        bus.src_packet[2] = mkpkt(1'b1, 7, 32'hDEAD);
        bus.src_valid     = 6'b000100;
        bus.cdb_ready     = 1'b1;
        #1;
        check("t2_src_ready", bus.src_ready, 6'b000100);
        check("t2_cdb_valid_n", bus.cdb_valid, 0);
        step();
        bus.src_valid = '0;
        #1;
        check("t2_cdb_valid", bus.cdb_valid, 1);
        check("t2_prf_wr_en", bus.prf_wr_en, 1);
        check("t2_prf_idx", bus.prf_wr_idx, 7);
        check("t2_prf_value", bus.prf_wr_value, 32'hDEAD);
        check("t2_occ", bus.occupancy, 1);
        step();
        check("t2_occ_drain", bus.occupancy, 0);

        // 3. all six lanes, rr_ptr restarted at 0 by a reset pulse
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) bus.src_packet[i] = mkpkt(1'b1, 10 + i, 32'h100 + i);
        bus.src_valid = 6'b111111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = 6'b000001 << c;
            check("t3_grant", bus.src_ready, exp_rdy);
            if (c > 0) begin
                check("t3_cdb_valid", bus.cdb_valid, 1);
                check("t3_cdb_idx", bus.prf_wr_idx, 10 + c - 1);
                check("t3_cdb_value", bus.prf_wr_value, 32'h100 + c - 1);
                check("t3_occ", bus.occupancy, 1);
            end else begin
                check("t3_cdb_valid_first", bus.cdb_valid, 0);
            end
            step();
            bus.src_valid[c] = 1'b0;
        end
        #1;
        check("t3_last_idx", bus.prf_wr_idx, 15);
        step();
        check("t3_drained", bus.occupancy, 0);

        // 4. fill to full with cdb stalled, then push+pop at full
        bus.cdb_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus.src_packet[i] = mkpkt(1'b1, 20 + i, 32'h200 + i);
        bus.src_valid = 6'b011111;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_rdy = 6'b000001 << c;
            check("t4_grant", bus.src_ready, exp_rdy);
            step();
            bus.src_valid[c] = 1'b0;
        end
        #1;
        check("t4_occ_full", bus.occupancy, 4);
        check("t4_fu_stall", bus.fu_stall, 1);
        check("t4_5th_blocked", bus.src_ready, 0);
        bus.cdb_ready = 1'b1;
        #1;
        check("t4_5th_granted", bus.src_ready, 6'b010000);
        check("t4_head_idx", bus.prf_wr_idx, 20);
        step();
        bus.src_valid = '0;
        bus.cdb_ready = 1'b0;
        #1;
        check("t4_occ_kept", bus.occupancy, 4);
        check("t4_next_head", bus.prf_wr_idx, 21);

        // 5. squash at occupancy 3
        bus.cdb_ready = 1'b1;
        step();
        bus.cdb_ready = 1'b0;
        #1;
        check("t5_occ3", bus.occupancy, 3);
        bus.squash        = 1'b1;
        bus.cdb_ready     = 1'b1;
        bus.src_packet[1] = mkpkt(1'b1, 30, 32'h300);
        bus.src_valid     = 6'b000010;
        #1;
        check("t5_sq_cdb_valid", bus.cdb_valid, 0);
        check("t5_sq_src_ready", bus.src_ready, 0);
        check("t5_sq_prf", bus.prf_wr_en, 0);
        step();
        bus.squash    = 1'b0;
        bus.cdb_ready = 1'b0;
        bus.src_valid = 6'b111111;
        #1;
        check("t5_occ0", bus.occupancy, 0);
        check("t5_cdb_valid", bus.cdb_valid, 0);
        check("t5_rr_kept", bus.src_ready, 6'b100000);
        bus.src_valid = '0;
        #1;

        // reset mid-operation drops buffered entries
        bus.src_packet[0] = mkpkt(1'b1, 40, 32'h400);
        bus.src_valid     = 6'b000001;
        step();
        bus.src_valid = '0;
        #1;
        check("rm_occ1", bus.occupancy, 1);
        reset = 1'b0;
        #1;
        check("rm_no_bcast", bus.cdb_valid, 0);
        step();
        reset = 1'b1;
        #1;
        check("rm_occ0", bus.occupancy, 0);
        check("rm_cdb_valid", bus.cdb_valid, 0);

        // 6. empty FIFO, lane 0, cdb ready: bypass vs. one-cycle latency
        bus.src_packet[0] = mkpkt(1'b1, 33, 32'hCAFE);
        bus.src_valid     = 6'b000001;
        bus.cdb_ready     = 1'b1;
        #1;
`ifdef CDB_BYPASS_EN
        check("t6_byp_valid", bus.cdb_valid, 1);
        check("t6_byp_prf", bus.prf_wr_en, 1);
        check("t6_byp_idx", bus.prf_wr_idx, 33);
        step();
        bus.src_valid = '0;
        #1;
        check("t6_byp_occ", bus.occupancy, 0);
        check("t6_byp_after", bus.cdb_valid, 0);
`else
        check("t6_valid_n", bus.cdb_valid, 0);
        step();
        bus.src_valid = '0;
        #1;
        check("t6_valid", bus.cdb_valid, 1);
        check("t6_occ1", bus.occupancy, 1);
        check("t6_idx", bus.prf_wr_idx, 33);
        step();
        check("t6_occ0", bus.occupancy, 0);
`endif

        // packet with .valid=0 broadcasts without a PRF write
        bus.cdb_ready     = 1'b0;
        bus.src_packet[1] = mkpkt(1'b0, 9, 32'h99);
        bus.src_valid     = 6'b000010;
        step();
        bus.src_valid = '0;
        bus.cdb_ready = 1'b1;
        #1;
        check("inv_cdb_valid", bus.cdb_valid, 1);
        check("inv_prf_wr_en", bus.prf_wr_en, 0);
        step();
        check("inv_drained", bus.occupancy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
